// File: rtl/bus_arbiter.sv
// Four-way round-robin bus arbiter with a one-cycle turnaround between owners.
// Define BUS_ARBITER_TIMEOUT_EN to bound every grant to TIMEOUT cycles.
module bus_arbiter #(
   parameter int NREQ    = 4,
   parameter int WIDTH   = 8,
   parameter int TIMEOUT = 16
) (
   input  logic                  clk,
   input  logic                  rstb,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ-1:0]       done,
   input  logic [NREQ*WIDTH-1:0] wdata,
   output logic [NREQ-1:0]       gnt,
   output logic [1:0]            gnt_id,
   output logic                  busy,
   output logic [WIDTH-1:0]      bus,
   output logic                  bus_oe,
   output logic                  timeout,
   output logic [1:0]            state_dbg
);

   // Handshake: a requester holds req high until it sees its gnt bit; it keeps
   // ownership while req stays high and ends it with a done pulse or by dropping req.
   typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, TURN = 2'd2} state_t;

   state_t     state;
   logic [1:0] ptr;
   logic       win_found;
   logic [1:0] win_id;
   logic [1:0] idx;
   logic       rel;
   logic       to_hit;

   always_comb begin
      win_found = 1'b0;
      win_id    = ptr;
      idx       = ptr;
      for (int k = 0; k < 4; k++) begin
         idx = ptr + 2'(k);
         if (!win_found && req[idx]) begin
            win_found = 1'b1;
            win_id    = idx;
         end
      end
   end

   assign rel = done[gnt_id] | ~req[gnt_id];

`ifdef BUS_ARBITER_TIMEOUT_EN
   logic [7:0] tcnt;
   // The counter reads 0 in the first GRANT cycle, so TIMEOUT-1 marks the last allowed one.
   assign to_hit = (tcnt == 8'(TIMEOUT - 1));
`else
   assign to_hit  = 1'b0;
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state  <= IDLE;
         gnt    <= '0;
         gnt_id <= '0;
         busy   <= 1'b0;
         ptr    <= '0;
`ifdef BUS_ARBITER_TIMEOUT_EN
         tcnt    <= '0;
         timeout <= 1'b0;
`endif
      end else begin
`ifdef BUS_ARBITER_TIMEOUT_EN
         timeout <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (win_found) begin
                  state       <= GRANT;
                  gnt         <= '0;
                  gnt[win_id] <= 1'b1;
                  gnt_id      <= win_id;
                  busy        <= 1'b1;
                  ptr         <= win_id + 2'd1;
`ifdef BUS_ARBITER_TIMEOUT_EN
                  tcnt        <= '0;
`endif
               end
            end
            GRANT: begin
`ifdef BUS_ARBITER_TIMEOUT_EN
               tcnt <= tcnt + 8'd1;
`endif
               if (rel || to_hit) begin
                  state <= TURN;
                  gnt   <= '0;
                  busy  <= 1'b0;
`ifdef BUS_ARBITER_TIMEOUT_EN
                  timeout <= !rel;
`endif
               end
            end
            TURN:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus       = busy ? wdata[gnt_id*WIDTH +: WIDTH] : '0;
   assign bus_oe    = busy;
   assign state_dbg = state;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter; with BUS_ARBITER_TIMEOUT_EN it also checks the forced release.
`timescale 1ns/1ps
module tb_bus_arbiter;

   logic        clk = 1'b0;
   logic        rstb = 1'b0;
   logic [3:0]  req = '0;
   logic [3:0]  done = '0;
   logic [31:0] wdata = '0;
   logic [3:0]  gnt;
   logic [1:0]  gnt_id;
   logic        busy;
   logic [7:0]  bus;
   logic        bus_oe;
   logic        timeout;
   logic [1:0]  state_dbg;

   int vec_cnt = 0;
   int err_cnt = 0;

   bus_arbiter #(.NREQ(4), .WIDTH(8), .TIMEOUT(16)) dut (
      .clk(clk), .rstb(rstb), .req(req), .done(done), .wdata(wdata),
      .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .bus(bus), .bus_oe(bus_oe),
      .timeout(timeout), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      vec_cnt++;
      if (!$onehot0(gnt)) begin
         err_cnt++;
         $display("FAIL gnt_onehot: got %b want at most one bit", gnt);
      end
   endtask

   task automatic do_reset();
      req  = '0;
      done = '0;
      @(negedge clk);
      rstb = 1'b0;
      @(negedge clk);
      rstb = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      req   = 4'b1111;
      wdata = 32'hDDCCBBAA;
      rstb  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      vec_cnt++;
      if ({gnt, gnt_id, busy, bus_oe, timeout, bus, state_dbg} !== 19'd0) begin
         err_cnt++;
         $display("FAIL reset_outputs: got gnt=%b id=%0d busy=%b oe=%b to=%b bus=%h st=%0d want all 0",
                  gnt, gnt_id, busy, bus_oe, timeout, bus, state_dbg);
      end
      req = '0;
   endtask

   task automatic test_basic();
      do_reset();
      wdata = 32'h000000A5;
      req   = 4'b0001;
      vec_cnt++;
      if (gnt !== 4'b0000) begin
         err_cnt++;
         $display("FAIL basic_no_early_gnt: got %b want 0000", gnt);
      end
      tick();
      vec_cnt++;
      if (gnt !== 4'b0001 || gnt_id !== 2'd0 || busy !== 1'b1) begin
         err_cnt++;
         $display("FAIL basic_grant: got gnt=%b id=%0d busy=%b want 0001/0/1", gnt, gnt_id, busy);
      end
      vec_cnt++;
      if (bus !== 8'hA5 || bus_oe !== 1'b1) begin
         err_cnt++;
         $display("FAIL basic_bus: got bus=%h oe=%b want a5/1", bus, bus_oe);
      end
      wdata = 32'h0000005A;
      #1;
      vec_cnt++;
      if (bus !== 8'h5A) begin
         err_cnt++;
         $display("FAIL basic_bus_comb: got %h want 5a", bus);
      end
      req = 4'b0000;
      tick();
      vec_cnt++;
      if (state_dbg !== 2'd2 || gnt !== 4'b0000 || bus !== 8'h00 || bus_oe !== 1'b0) begin
         err_cnt++;
         $display("FAIL basic_turn: got st=%0d gnt=%b bus=%h oe=%b want 2/0000/00/0", state_dbg, gnt, bus, bus_oe);
      end
      tick();
      vec_cnt++;
      if (state_dbg !== 2'd0) begin
         err_cnt++;
         $display("FAIL basic_idle: got st=%0d want 0", state_dbg);
      end
   endtask

   task automatic test_round_robin();
      int order[5] = '{0, 1, 2, 3, 0};
      logic [3:0] exp_g;
      do_reset();
      wdata = 32'h13121110;
      req   = 4'b1111;
      tick();
      for (int k = 0; k < 5; k++) begin
         exp_g = 4'b0001 << order[k];
         vec_cnt++;
         if (gnt !== exp_g || gnt_id !== 2'(order[k]) || bus !== 8'(8'h10 + order[k])) begin
            err_cnt++;
            $display("FAIL rr_grant%0d: got gnt=%b id=%0d bus=%h want %b/%0d/%h",
                     k, gnt, gnt_id, bus, exp_g, order[k], 8'(8'h10 + order[k]));
         end
         tick();
         vec_cnt++;
         if (gnt !== exp_g) begin
            err_cnt++;
            $display("FAIL rr_hold%0d: got %b want %b", k, gnt, exp_g);
         end
         done = exp_g;
         tick();
         done = 4'b0000;
         vec_cnt++;
         if (gnt !== 4'b0000 || state_dbg !== 2'd2) begin
            err_cnt++;
            $display("FAIL rr_turn%0d: got gnt=%b st=%0d want 0000/2", k, gnt, state_dbg);
         end
         tick();
         vec_cnt++;
         if (gnt !== 4'b0000 || state_dbg !== 2'd0) begin
            err_cnt++;
            $display("FAIL rr_idle%0d: got gnt=%b st=%0d want 0000/0", k, gnt, state_dbg);
         end
         tick();
      end
      req = 4'b0000;
   endtask

   task automatic test_ignore_done();
      do_reset();
      req  = 4'b0100;
      done = 4'b0100;
      tick();
      done = 4'b0000;
      vec_cnt++;
      if (gnt !== 4'b0100 || gnt_id !== 2'd2) begin
         err_cnt++;
         $display("FAIL idle_done_ignored: got gnt=%b id=%0d want 0100/2", gnt, gnt_id);
      end
      tick();
      done = 4'b0001;
      tick();
      done = 4'b0000;
      vec_cnt++;
      if (gnt !== 4'b0100 || busy !== 1'b1) begin
         err_cnt++;
         $display("FAIL nonowner_done: got gnt=%b busy=%b want 0100/1", gnt, busy);
      end
      req = 4'b0000;
      tick();
      vec_cnt++;
      if (state_dbg !== 2'd2 || gnt !== 4'b0000) begin
         err_cnt++;
         $display("FAIL req_drop_turn: got st=%0d gnt=%b want 2/0000", state_dbg, gnt);
      end
      done = 4'b1111;
      tick();
      done = 4'b0000;
      vec_cnt++;
      if (state_dbg !== 2'd0) begin
         err_cnt++;
         $display("FAIL req_drop_idle: got st=%0d want 0", state_dbg);
      end
      tick();
      vec_cnt++;
      if (state_dbg !== 2'd0 || busy !== 1'b0) begin
         err_cnt++;
         $display("FAIL idle_stays: got st=%0d busy=%b want 0/0", state_dbg, busy);
      end
   endtask

   task automatic test_reset_mid_grant();
      do_reset();
      wdata = 32'hC3000000;
      req   = 4'b1000;
      tick();
      vec_cnt++;
      if (gnt !== 4'b1000 || bus !== 8'hC3) begin
         err_cnt++;
         $display("FAIL mid_pre: got gnt=%b bus=%h want 1000/c3", gnt, bus);
      end
      #2 rstb = 1'b0;
      #1;
      vec_cnt++;
      if (gnt !== 4'b0000 || bus !== 8'h00 || busy !== 1'b0 || state_dbg !== 2'd0) begin
         err_cnt++;
         $display("FAIL mid_async: got gnt=%b bus=%h busy=%b st=%0d want 0000/00/0/0", gnt, bus, busy, state_dbg);
      end
      req = 4'b1001;
      @(negedge clk);
      rstb = 1'b1;
      tick();
      vec_cnt++;
      if (gnt !== 4'b0001 || gnt_id !== 2'd0) begin
         err_cnt++;
         $display("FAIL mid_after: got gnt=%b id=%0d want 0001/0", gnt, gnt_id);
      end
      req = 4'b0000;
   endtask

   task automatic test_back_to_back();
      do_reset();
      req = 4'b0001;
      tick();
      done = 4'b0001;
      req  = 4'b0011;
      tick();
      done = 4'b0000;
      vec_cnt++;
      if (gnt !== 4'b0000 || state_dbg !== 2'd2) begin
         err_cnt++;
         $display("FAIL b2b_turn: got gnt=%b st=%0d want 0000/2", gnt, state_dbg);
      end
      tick();
      vec_cnt++;
      if (gnt !== 4'b0000 || state_dbg !== 2'd0) begin
         err_cnt++;
         $display("FAIL b2b_idle: got gnt=%b st=%0d want 0000/0", gnt, state_dbg);
      end
      tick();
      vec_cnt++;
      if (gnt !== 4'b0010 || gnt_id !== 2'd1) begin
         err_cnt++;
         $display("FAIL b2b_next: got gnt=%b id=%0d want 0010/1", gnt, gnt_id);
      end
      req = 4'b0000;
   endtask

   task automatic test_timeout();
      do_reset();
      req = 4'b0010;
      tick();
`ifdef BUS_ARBITER_TIMEOUT_EN
      for (int c = 2; c <= 16; c++) begin
         tick();
         vec_cnt++;
         if (gnt !== 4'b0010 || timeout !== 1'b0) begin
            err_cnt++;
            $display("FAIL to_hold%0d: got gnt=%b to=%b want 0010/0", c, gnt, timeout);
         end
      end
      tick();
      vec_cnt++;
      if (gnt !== 4'b0000 || timeout !== 1'b1 || state_dbg !== 2'd2) begin
         err_cnt++;
         $display("FAIL to_release: got gnt=%b to=%b st=%0d want 0000/1/2", gnt, timeout, state_dbg);
      end
      req = 4'b1111;
      tick();
      vec_cnt++;
      if (timeout !== 1'b0 || state_dbg !== 2'd0) begin
         err_cnt++;
         $display("FAIL to_pulse_end: got to=%b st=%0d want 0/0", timeout, state_dbg);
      end
      tick();
      vec_cnt++;
      if (gnt !== 4'b0100) begin
         err_cnt++;
         $display("FAIL to_ptr: got %b want 0100", gnt);
      end
`else
      for (int c = 2; c <= 40; c++) begin
         tick();
         vec_cnt++;
         if (gnt !== 4'b0010 || timeout !== 1'b0) begin
            err_cnt++;
            $display("FAIL no_to_hold%0d: got gnt=%b to=%b want 0010/0", c, gnt, timeout);
         end
      end
`endif
      req = 4'b0000;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_round_robin();
      test_ignore_done();
      test_reset_mid_grant();
      test_back_to_back();
      test_timeout();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
